compare_scan: RTL and testbench

- Parametrised successor to the lab1 two-player input comparator.
- Compares two WIDTH-bit player input vectors every clock and reports the index of the first differing bit on a code output. The code blinks (index / blank) with a programmable phase length.
- Also reports a full-match flag and a popcount of mismatching bits.
- Sits between the two players' input capture logic and the 7-segment/LED display driver. Active only in advance or practice mode.

---
 rtl/compare_scan.sv | 144 ++++++++++++++
 tb/tb_compare_scan.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/compare_scan.sv
// compare_scan: compares two player vectors every clock, reports the first
// differing bit index as a blinking code, plus full-match flag and the
// number of mismatching bits. All outputs are registered (1-cycle latency).
// WIDTH must not exceed 2**CODEW - 2 so indices never collide with the
// BLANK/IDLE codes.
module compare_scan #(
    parameter int WIDTH     = 10,
    parameter int CODEW     = 4,
    parameter int BLINK_DIV = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             one_input,
    input  logic [WIDTH-1:0]             two_input,
    input  logic                         advance,
    input  logic                         practicle,
    input  logic                         msb_first,
    output logic [CODEW-1:0]             change,
    output logic                         match,
    output logic [$clog2(WIDTH+1)-1:0]   diff_count
);

    localparam int DCW  = $clog2(WIDTH + 1);
    localparam int CNTW = $clog2(BLINK_DIV + 1);

    localparam logic [CODEW-1:0] BLANK_CODE = {CODEW{1'b1}};
    localparam logic [CODEW-1:0] IDLE_CODE  = {{(CODEW-1){1'b1}}, 1'b0};
    localparam logic [CNTW-1:0]  CNT_LAST   = CNTW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_BLANK,
        S_MATCH
    } state_t;

    state_t               state_q, state_d;
    logic [CODEW-1:0]     idx_q, idx_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [CODEW-1:0]     change_q, change_d;
    logic                 match_q, match_d;
    logic [DCW-1:0]       count_q, count_d;

    logic [WIDTH-1:0]     diff_vec;
    logic                 any_diff;
    logic [CODEW-1:0]     first_idx;
    logic [DCW-1:0]       pop;
    logic                 en;

    assign en = advance | practicle;

    // Mismatch vector, priority scan in the selected direction, and popcount.
    always_comb begin
        diff_vec  = one_input ^ two_input;
        any_diff  = |diff_vec;
        first_idx = '0;
        pop       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + DCW'(diff_vec[i]);
        end
        if (msb_first) begin
            // Ascending walk: the last hit is the highest set bit.
            for (int i = 0; i < WIDTH; i++) begin
                if (diff_vec[i]) first_idx = CODEW'(i);
            end
        end else begin
            // Descending walk: the last hit is the lowest set bit.
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (diff_vec[i]) first_idx = CODEW'(i);
            end
        end
    end

    // Next-state and registered-output values, highest-priority rule first.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        change_d = change_q;
        match_d  = match_q;
        count_d  = count_q;

        if (!en) begin
            state_d  = S_IDLE;
            change_d = IDLE_CODE;
            match_d  = 1'b0;
            count_d  = '0;
            cnt_d    = '0;
        end else begin
            count_d = pop;
            if (!any_diff) begin
                state_d  = S_MATCH;
                change_d = BLANK_CODE;
                match_d  = 1'b1;
                cnt_d    = '0;
            end else if (state_q == S_IDLE || state_q == S_MATCH || first_idx != idx_q) begin
                // New or changed index: restart the blink at SHOW.
                state_d  = S_SHOW;
                idx_d    = first_idx;
                change_d = first_idx;
                match_d  = 1'b0;
                cnt_d    = '0;
            end else if (cnt_q < CNT_LAST) begin
                // Same index, phase not yet complete: hold the current phase.
                cnt_d   = cnt_q + CNTW'(1);
                match_d = 1'b0;
            end else if (state_q == S_SHOW) begin
                state_d  = S_BLANK;
                change_d = BLANK_CODE;
                match_d  = 1'b0;
                cnt_d    = '0;
            end else begin
                state_d  = S_SHOW;
                change_d = idx_q;
                match_d  = 1'b0;
                cnt_d    = '0;
            end
        end
    end

    // State and output registers; reset forces IDLE values immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            change_q <= IDLE_CODE;
            match_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            change_q <= change_d;
            match_q  <= match_d;
            count_q  <= count_d;
        end
    end

    assign change     = change_q;
    assign match      = match_q;
    assign diff_count = count_q;

endmodule

// File: tb/tb_compare_scan.sv
// Directed bench for compare_scan: two instances (BLINK_DIV=1 and 3) share
// the same stimulus; each scenario task checks the instance it targets.
module tb_compare_scan;

    logic        clk;
    logic        reset;
    logic [9:0]  one_input;
    logic [9:0]  two_input;
    logic        advance;
    logic        practicle;
    logic        msb_first;

    logic [3:0]  change1, change3;
    logic        match1, match3;
    logic [3:0]  count1, count3;

    int n_cmp;
    int n_bad;

    compare_scan #(.WIDTH(10), .CODEW(4), .BLINK_DIV(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .one_input  (one_input),
        .two_input  (two_input),
        .advance    (advance),
        .practicle  (practicle),
        .msb_first  (msb_first),
        .change     (change1),
        .match      (match1),
        .diff_count (count1)
    );

    compare_scan #(.WIDTH(10), .CODEW(4), .BLINK_DIV(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .one_input  (one_input),
        .two_input  (two_input),
        .advance    (advance),
        .practicle  (practicle),
        .msb_first  (msb_first),
        .change     (change3),
        .match      (match3),
        .diff_count (count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        advance   = 1'b0;
        practicle = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; advance = 1'b0; practicle = 1'b0; msb_first = 1'b0;
        one_input = 10'h000; two_input = 10'h3FF;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) reset = 1'b1;
            tick();
            n_cmp++;
            if (change1 !== 4'hE || match1 !== 1'b0 || count1 !== 4'd0) begin
                n_bad++;
                $display("FAIL reset_dut1 cyc%0d: got change=%0d match=%0b cnt=%0d, want 14/0/0", c, change1, match1, count1);
            end
            n_cmp++;
            if (change3 !== 4'hE || match3 !== 1'b0 || count3 !== 4'd0) begin
                n_bad++;
                $display("FAIL reset_dut3 cyc%0d: got change=%0d match=%0b cnt=%0d, want 14/0/0", c, change3, match3, count3);
            end
            $display("reset cyc%0d: change1=%0d change3=%0d", c, change1, change3);
        end
    endtask

    task automatic test_legacy_blink();
        go_idle();
        one_input = 10'h000; two_input = 10'h004; msb_first = 1'b0; practicle = 1'b1;
        for (int c = 0; c < 6; c++) begin
            logic [3:0] exp;
            exp = (c % 2 == 0) ? 4'd2 : 4'd15;
            tick();
            n_cmp++;
            if (change1 !== exp || match1 !== 1'b0 || count1 !== 4'd1) begin
                n_bad++;
                $display("FAIL legacy cyc%0d: got change=%0d match=%0b cnt=%0d, want %0d/0/1", c, change1, match1, count1, exp);
            end
            $display("legacy cyc%0d: change=%0d", c, change1);
        end
    endtask

    task automatic test_priority_direction();
        logic [3:0] exp1 [4] = '{4'd0, 4'd15, 4'd9, 4'd15};
        logic [3:0] exp3 [4] = '{4'd0, 4'd0, 4'd9, 4'd9};
        go_idle();
        one_input = 10'h000; two_input = 10'h211; msb_first = 1'b0; advance = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) msb_first = 1'b1;
            tick();
            n_cmp++;
            if (change1 !== exp1[c] || count1 !== 4'd3) begin
                n_bad++;
                $display("FAIL prio_dut1 cyc%0d: got change=%0d cnt=%0d, want %0d/3", c, change1, count1, exp1[c]);
            end
            n_cmp++;
            if (change3 !== exp3[c] || count3 !== 4'd3) begin
                n_bad++;
                $display("FAIL prio_dut3 cyc%0d: got change=%0d cnt=%0d, want %0d/3", c, change3, count3, exp3[c]);
            end
            $display("prio cyc%0d msb_first=%0b: change1=%0d change3=%0d", c, msb_first, change1, change3);
        end
        msb_first = 1'b0;
    endtask

    // Leaves dut3 in BLANK with its phase counter at 1.
    task automatic test_programmable_phase();
        go_idle();
        one_input = 10'h000; two_input = 10'h020; msb_first = 1'b0; advance = 1'b1;
        for (int c = 0; c < 11; c++) begin
            logic [3:0] exp;
            exp = ((c / 3) % 2 == 0) ? 4'd5 : 4'd15;
            tick();
            n_cmp++;
            if (change3 !== exp || match3 !== 1'b0 || count3 !== 4'd1) begin
                n_bad++;
                $display("FAIL phase cyc%0d: got change=%0d match=%0b cnt=%0d, want %0d/0/1", c, change3, match3, count3, exp);
            end
            $display("phase cyc%0d: change3=%0d", c, change3);
        end
    endtask

    task automatic test_midphase_and_match();
        logic [3:0] exp [4] = '{4'd7, 4'd7, 4'd7, 4'd15};
        two_input = 10'h080;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (change3 !== exp[c]) begin
                n_bad++;
                $display("FAIL newidx cyc%0d: got change=%0d, want %0d", c, change3, exp[c]);
            end
            $display("newidx cyc%0d: change3=%0d", c, change3);
        end
        // Both modes high, then clear the mismatch.
        practicle = 1'b1;
        two_input = 10'h000;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (change3 !== 4'd15 || match3 !== 1'b1 || count3 !== 4'd0) begin
                n_bad++;
                $display("FAIL match_dut3 cyc%0d: got change=%0d match=%0b cnt=%0d, want 15/1/0", c, change3, match3, count3);
            end
            n_cmp++;
            if (change1 !== 4'd15 || match1 !== 1'b1 || count1 !== 4'd0) begin
                n_bad++;
                $display("FAIL match_dut1 cyc%0d: got change=%0d match=%0b cnt=%0d, want 15/1/0", c, change1, match1, count1);
            end
            $display("match cyc%0d: change3=%0d match3=%0b", c, change3, match3);
        end
        // Mismatch back, then disable: IDLE clears the count.
        two_input = 10'h300;
        tick();
        n_cmp++;
        if (change3 !== 4'd8 || count3 !== 4'd2 || match3 !== 1'b0) begin
            n_bad++;
            $display("FAIL rediff: got change=%0d cnt=%0d match=%0b, want 8/2/0", change3, count3, match3);
        end
        $display("rediff: change3=%0d cnt3=%0d", change3, count3);
        go_idle();
        n_cmp++;
        if (change3 !== 4'hE || count3 !== 4'd0 || match3 !== 1'b0) begin
            n_bad++;
            $display("FAIL disable: got change=%0d cnt=%0d match=%0b, want 14/0/0", change3, count3, match3);
        end
        $display("disable: change3=%0d", change3);
    endtask

    task automatic test_async_reset();
        one_input = 10'h000; two_input = 10'h004; msb_first = 1'b0; advance = 1'b1;
        tick();
        n_cmp++;
        if (change1 !== 4'd2) begin
            n_bad++;
            $display("FAIL pre_rst: got change=%0d, want 2", change1);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (change1 !== 4'hE || match1 !== 1'b0 || count1 !== 4'd0) begin
            n_bad++;
            $display("FAIL async_rst: got change=%0d match=%0b cnt=%0d, want 14/0/0", change1, match1, count1);
        end
        $display("async reset: change1=%0d", change1);
        tick();
        n_cmp++;
        if (change1 !== 4'hE) begin
            n_bad++;
            $display("FAIL rst_hold: got change=%0d, want 14", change1);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (change1 !== 4'd2 || count1 !== 4'd1) begin
            n_bad++;
            $display("FAIL post_rst: got change=%0d cnt=%0d, want 2/1", change1, count1);
        end
        $display("post reset: change1=%0d", change1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_legacy_blink();
        test_priority_direction();
        test_programmable_phase();
        test_midphase_and_match();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
